sdma_intr_hub: RTL and testbench
================================

Name: sdma_intr_hub

Overview:
Parametrised successor to the fixed one-client SDMA hookup, where channel 0 carries one requester and the other request bits are tied to zero.
- Arbitrates NUM_CLIENTS FPGA DMA clients (decimation filter, I2S RX, AEC reference, etc.) onto one SDMA channel.
- Routes done/active back to the granted client.
- Aggregates per-client done and timeout events into one maskable FB interrupt.
- Sits between the FPGA IP clients and the qlal4s3b SDMA/FB_msg_out pins, with a Wishbone register window.

Parameters:
NUM_CLIENTS, 4, number of DMA clients (1..8)
OWNER_W, 3, width of owner index (>= clog2(NUM_CLIENTS))
TIMEOUT_DEFAULT, 16'd4096, reset value of TIMEOUT_LIMIT register (0 = timeout disabled)

Ports:
WB_CLK  in  1  single clock (Wishbone clock)
WB_RST_n  in  1  asynchronous active-low reset
WBs_ADR_i  in  2  word index into register window
WBs_CYC_i  in  1  cycle select
WBs_STB_i  in  1  strobe
WBs_WE_i  in  1  write enable
WBs_BYTE_STB_i  in  4  byte enables
WBs_WR_DAT_i  in  32  write data
WBs_RD_DAT_o  out  32  registered read data
WBs_ACK_o  out  1  one-cycle acknowledge
Client_Req_i  in  NUM_CLIENTS  per-client DMA request (level)
Client_Sreq_i  in  NUM_CLIENTS  per-client single request
Client_Done_o  out  NUM_CLIENTS  one-cycle done pulse to owner
Client_Active_o  out  NUM_CLIENTS  SDMA active routed to owner
SDMA_Req_o  out  1  to SDMA_Req[ch]
SDMA_Sreq_o  out  1  to SDMA_Sreq[ch]
SDMA_Done_i  in  1  from SDMA_Done[ch], one-cycle pulse
SDMA_Active_i  in  1  from SDMA_Active[ch]
Intr_o  out  1  to FB_msg_out bit, level

Behaviour:
- Clock and reset: one clock, WB_CLK. Reset WB_RST_n is asynchronous, active-low.
- Reset values:
  - All outputs 0; FSM IDLE; owner 0; rr_ptr 0.
  - STATUS 0, ENABLE 0, TIMEOUT_LIMIT = TIMEOUT_DEFAULT.
  - Reset asserted mid-transfer drops SDMA_Req_o/Client_Active_o immediately. No done pulse is generated.
- Wishbone:
  - WBs_ACK_o rises the cycle after CYC&STB&~ACK and stays high one cycle.
  - Writes commit on the edge that raises ACK; byte enables are honoured.
  - Read data is valid with ACK.
- Register map (word index):
  - 0 STATUS: [NUM_CLIENTS-1:0] done sticky; [8+NUM_CLIENTS-1:8] timeout sticky. Write-1-to-clear. A set in the same cycle as a clear wins.
  - 1 ENABLE: same bit layout as STATUS, as interrupt enables; [31] ARB_MODE (0 fixed priority, 1 round robin).
  - 2 OWNER (RO): [OWNER_W-1:0] current/last owner; [8] busy (state != IDLE); [17:16] FSM state code.
  - 3 TIMEOUT_LIMIT: [15:0] RW.
  - Unused bits read 0.
- Interrupt: Intr_o registered = |(STATUS & ENABLE); one cycle after the status bit sets.
- FSM states: IDLE(0), REQ(1), ACTIVE(2), RELEASE(3).
  - IDLE: if |Client_Req_i, select winner, latch owner, clear timer, go REQ.
    - Fixed priority: lowest index wins.
    - Round robin: first requester at or after rr_ptr, wrapping at NUM_CLIENTS.
  - REQ:
    - SDMA_Req_o = Client_Req_i[owner]; SDMA_Sreq_o = Client_Sreq_i[owner].
    - Timer increments each cycle. SDMA_Active_i -> ACTIVE.
    - Timer == LIMIT (LIMIT != 0) -> set timeout[owner], go RELEASE.
    - Client_Req_i[owner] and Sreq both low before Active -> RELEASE (cancel, no status).
    - SDMA_Done_i seen in REQ is treated as completion (same as ACTIVE).
  - ACTIVE:
    - Client_Active_o[owner] = SDMA_Active_i; all other Client_Active_o bits 0.
    - SDMA_Req_o/Sreq are passed through from the owner as in REQ.
    - On SDMA_Done_i: Client_Done_o[owner] pulses the next cycle; done[owner] sets; go RELEASE.
    - No timeout in ACTIVE.
  - RELEASE: one cycle; SDMA_Req_o = SDMA_Sreq_o = 0; rr_ptr = owner+1 (wrap to 0); -> IDLE.
- Latency:
  - Client request high while IDLE at edge N -> SDMA_Req_o high from cycle N+1.
  - Minimum back-to-back gap between grants: 2 cycles (RELEASE, IDLE).
- Changing ARB_MODE takes effect at the next IDLE decision. The owner never changes mid-transfer.
- Requests from client indices >= NUM_CLIENTS do not exist; OWNER upper bits read 0.

Decomposition:
- Shared package sdma_hub_pkg holds:
  - FSM state encoding.
  - Register word indices.
  - STATUS bit offsets (DONE_LSB=0, TMO_LSB=8).
  - ARB_MODE bit 31.
- One natural sub-module: sdma_rr_arbiter (request vector, rr_ptr, mode -> winner index + valid), purely combinational.
- Registers, FSM and timer stay in sdma_intr_hub.

Test Plan:
- Single client: Client_Req_i=4'b0010, Active 3 cycles after Req, Done pulse -> SDMA_Req_o high at N+1; Client_Active_o=4'b0010 while active; Client_Done_o[1] one-cycle pulse; STATUS=0x2; with ENABLE=0x2, Intr_o=1; write STATUS=0x2 -> Intr_o=0.
- Fixed priority: all four request continuously, ARB_MODE=0 -> grants 0,0,0,... ; with ARB_MODE=1 -> grants 0,1,2,3,0; OWNER register matches each grant.
- Timeout: TIMEOUT_LIMIT=8, client 2 requests, no Active -> SDMA_Req_o drops after 9 cycles in REQ; STATUS=0x400; Client_Done_o stays 0.
- Cancel: client 3 raises then drops Req before Active -> RELEASE, STATUS unchanged, next requester granted.
- W1C vs set collision: write STATUS=0x1 in the same cycle SDMA_Done_i completes client 0 -> STATUS bit 0 remains 1.
- Async reset asserted in ACTIVE -> all outputs 0 without a clock; after release, TIMEOUT_LIMIT reads 4096, STATUS reads 0.

Source files
------------

// File: rtl/sdma_hub_pkg.sv
// Shared definitions for the SDMA interrupt hub: FSM encoding, register
// window layout and byte-enable helper.
package sdma_hub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } hub_state_e;

  // Register word indices
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_OWNER   = 2'd2;
  localparam logic [1:0] REG_TIMEOUT = 2'd3;

  // STATUS / ENABLE bit layout
  localparam int unsigned DONE_LSB     = 0;
  localparam int unsigned TMO_LSB      = 8;
  localparam int unsigned ARB_MODE_BIT = 31;

  // OWNER register layout
  localparam int unsigned OWNER_BUSY_BIT  = 8;
  localparam int unsigned OWNER_STATE_LSB = 16;

  // Expand the four Wishbone byte strobes into a 32-bit bit mask
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sdma_rr_arbiter.sv
// Combinational client arbiter: fixed priority (lowest index) or round robin
// starting at the pointer and wrapping at NUM_CLIENTS.
module sdma_rr_arbiter #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned OWNER_W     = 3
) (
  input  logic [NUM_CLIENTS-1:0] i_req,
  input  logic [OWNER_W-1:0]     i_rr_ptr,
  input  logic                   i_rr_mode,
  output logic [OWNER_W-1:0]     o_winner,
  output logic                   o_valid
);

  logic [OWNER_W-1:0] w_lo_idx;
  logic [OWNER_W-1:0] w_hi_idx;
  logic               w_lo_vld;
  logic               w_hi_vld;

  // Lowest requester overall, and lowest requester at or above the pointer;
  // round robin prefers the latter and wraps to the former.
  always_comb begin
    w_lo_idx = '0;
    w_lo_vld = 1'b0;
    w_hi_idx = '0;
    w_hi_vld = 1'b0;
    for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
      if (i_req[j] && !w_lo_vld) begin
        w_lo_vld = 1'b1;
        w_lo_idx = OWNER_W'(j);
      end
      if (i_req[j] && !w_hi_vld && (j >= 32'(i_rr_ptr))) begin
        w_hi_vld = 1'b1;
        w_hi_idx = OWNER_W'(j);
      end
    end
  end

  assign o_valid  = w_lo_vld;
  assign o_winner = (i_rr_mode && w_hi_vld) ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/sdma_intr_hub.sv
// Multi-client SDMA channel hub: arbitrates client requests onto one SDMA
// channel, routes done/active to the owner, and raises a maskable interrupt
// from sticky done/timeout status. Wishbone register window.
module sdma_intr_hub
  import sdma_hub_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS     = 4,
  parameter int unsigned OWNER_W         = 3,
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'd4096
) (
  input  logic                   WB_CLK,
  input  logic                   WB_RST_n,
  input  logic [1:0]             WBs_ADR_i,
  input  logic                   WBs_CYC_i,
  input  logic                   WBs_STB_i,
  input  logic                   WBs_WE_i,
  input  logic [3:0]             WBs_BYTE_STB_i,
  input  logic [31:0]            WBs_WR_DAT_i,
  output logic [31:0]            WBs_RD_DAT_o,
  output logic                   WBs_ACK_o,
  input  logic [NUM_CLIENTS-1:0] Client_Req_i,
  input  logic [NUM_CLIENTS-1:0] Client_Sreq_i,
  output logic [NUM_CLIENTS-1:0] Client_Done_o,
  output logic [NUM_CLIENTS-1:0] Client_Active_o,
  output logic                   SDMA_Req_o,
  output logic                   SDMA_Sreq_o,
  input  logic                   SDMA_Done_i,
  input  logic                   SDMA_Active_i,
  output logic                   Intr_o
);

  hub_state_e             r_state;
  hub_state_e             w_state_nxt;
  logic [OWNER_W-1:0]     r_owner;
  logic [OWNER_W-1:0]     r_rr_ptr;
  logic [15:0]            r_timer;
  logic [15:0]            r_tmo_limit;
  logic [NUM_CLIENTS-1:0] r_done_st;
  logic [NUM_CLIENTS-1:0] r_tmo_st;
  logic [NUM_CLIENTS-1:0] r_en_done;
  logic [NUM_CLIENTS-1:0] r_en_tmo;
  logic [NUM_CLIENTS-1:0] r_done_pulse;
  logic                   r_arb_mode;
  logic                   r_ack;
  logic                   r_intr;
  logic [31:0]            r_rd_dat;

  logic [OWNER_W-1:0]     w_win;
  logic                   w_win_vld;
  logic [NUM_CLIENTS-1:0] w_owner_oh;
  logic                   w_owner_req;
  logic                   w_owner_sreq;
  logic                   w_set_done;
  logic                   w_set_tmo;
  logic                   w_wb_go;
  logic                   w_wb_wr;
  logic                   w_st_wr;
  logic [31:0]            w_mask;
  logic [31:0]            w_wclr;
  logic [31:0]            w_merge;
  logic [31:0]            w_rd_word;
  logic [NUM_CLIENTS-1:0] w_done_clr;
  logic [NUM_CLIENTS-1:0] w_tmo_clr;
  logic                   w_unused_bits;

  sdma_rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .OWNER_W     (OWNER_W)
  ) u_arb (
    .i_req     (Client_Req_i),
    .i_rr_ptr  (r_rr_ptr),
    .i_rr_mode (r_arb_mode),
    .o_winner  (w_win),
    .o_valid   (w_win_vld)
  );

  assign w_owner_oh   = NUM_CLIENTS'(1) << r_owner;
  assign w_owner_req  = |(Client_Req_i & w_owner_oh);
  assign w_owner_sreq = |(Client_Sreq_i & w_owner_oh);

  // FSM state register
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // FSM next state, SDMA/client routing and status set events
  always_comb begin
    w_state_nxt     = r_state;
    w_set_done      = 1'b0;
    w_set_tmo       = 1'b0;
    SDMA_Req_o      = 1'b0;
    SDMA_Sreq_o     = 1'b0;
    Client_Active_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        SDMA_Req_o  = w_owner_req;
        SDMA_Sreq_o = w_owner_sreq;
        if (SDMA_Done_i) begin
          w_set_done  = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (SDMA_Active_i) begin
          w_state_nxt = ST_ACTIVE;
        end else if ((r_tmo_limit != '0) && (r_timer == r_tmo_limit)) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (!w_owner_req && !w_owner_sreq) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_ACTIVE: begin
        SDMA_Req_o      = w_owner_req;
        SDMA_Sreq_o     = w_owner_sreq;
        Client_Active_o = w_owner_oh & {NUM_CLIENTS{SDMA_Active_i}};
        if (SDMA_Done_i) begin
          w_set_done  = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Owner latch, request timer and round-robin pointer
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_owner  <= '0;
      r_timer  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_state == ST_IDLE && w_win_vld) begin
        r_owner <= w_win;
        r_timer <= '0;
      end else if (r_state == ST_REQ) begin
        r_timer <= r_timer + 16'd1;
      end else if (r_state == ST_RELEASE) begin
        r_rr_ptr <= (r_owner == OWNER_W'(NUM_CLIENTS - 1)) ? '0 : r_owner + OWNER_W'(1);
      end
    end
  end

  // One-cycle done pulse to the owning client
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) r_done_pulse <= '0;
    else           r_done_pulse <= w_set_done ? w_owner_oh : '0;
  end

  assign Client_Done_o = r_done_pulse;

  // Wishbone decode
  assign w_wb_go  = WBs_CYC_i & WBs_STB_i & ~r_ack;
  assign w_wb_wr  = w_wb_go & WBs_WE_i;
  assign w_st_wr  = w_wb_wr && (WBs_ADR_i == REG_STATUS);
  assign w_mask   = be_to_mask(WBs_BYTE_STB_i);
  assign w_wclr   = WBs_WR_DAT_i & w_mask;
  assign w_merge  = (w_rd_word & ~w_mask) | w_wclr;
  assign w_done_clr = w_st_wr ? w_wclr[DONE_LSB +: NUM_CLIENTS] : '0;
  assign w_tmo_clr  = w_st_wr ? w_wclr[TMO_LSB  +: NUM_CLIENTS] : '0;
  assign w_unused_bits = ^{w_merge, w_wclr};

  // Read mux over the register window; unused bits read 0
  always_comb begin
    w_rd_word = '0;
    case (WBs_ADR_i)
      REG_STATUS: begin
        w_rd_word[DONE_LSB +: NUM_CLIENTS] = r_done_st;
        w_rd_word[TMO_LSB  +: NUM_CLIENTS] = r_tmo_st;
      end
      REG_ENABLE: begin
        w_rd_word[DONE_LSB +: NUM_CLIENTS] = r_en_done;
        w_rd_word[TMO_LSB  +: NUM_CLIENTS] = r_en_tmo;
        w_rd_word[ARB_MODE_BIT]            = r_arb_mode;
      end
      REG_OWNER: begin
        w_rd_word[OWNER_W-1:0]             = r_owner;
        w_rd_word[OWNER_BUSY_BIT]          = (r_state != ST_IDLE);
        w_rd_word[OWNER_STATE_LSB +: 2]    = r_state;
      end
      default: begin
        w_rd_word[15:0] = r_tmo_limit;
      end
    endcase
  end

  // Wishbone acknowledge and registered read data
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_ack    <= 1'b0;
      r_rd_dat <= '0;
    end else begin
      r_ack    <= w_wb_go;
      r_rd_dat <= (w_wb_go && !WBs_WE_i) ? w_rd_word : '0;
    end
  end

  assign WBs_ACK_o    = r_ack;
  assign WBs_RD_DAT_o = r_rd_dat;

  // ENABLE / ARB_MODE and TIMEOUT_LIMIT writes with byte merging
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_en_done   <= '0;
      r_en_tmo    <= '0;
      r_arb_mode  <= 1'b0;
      r_tmo_limit <= TIMEOUT_DEFAULT;
    end else if (w_wb_wr) begin
      case (WBs_ADR_i)
        REG_ENABLE: begin
          r_en_done  <= w_merge[DONE_LSB +: NUM_CLIENTS];
          r_en_tmo   <= w_merge[TMO_LSB  +: NUM_CLIENTS];
          r_arb_mode <= w_merge[ARB_MODE_BIT];
        end
        REG_TIMEOUT: r_tmo_limit <= w_merge[15:0];
        default: ;
      endcase
    end
  end

  // Sticky status, write-1-to-clear; a same-cycle set overrides the clear
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_done_st <= '0;
      r_tmo_st  <= '0;
    end else begin
      r_done_st <= (r_done_st & ~w_done_clr) | (w_set_done ? w_owner_oh : '0);
      r_tmo_st  <= (r_tmo_st  & ~w_tmo_clr)  | (w_set_tmo  ? w_owner_oh : '0);
    end
  end

  // Registered interrupt from enabled sticky status
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) r_intr <= 1'b0;
    else           r_intr <= |((r_done_st & r_en_done) | (r_tmo_st & r_en_tmo));
  end

  assign Intr_o = r_intr;

endmodule

// File: tb/tb_sdma_intr_hub.sv
// Directed bench for sdma_intr_hub with an owner scoreboard.
module tb_sdma_intr_hub;

  localparam int unsigned NC = 4;
  localparam logic [1:0] A_STATUS  = 2'd0;
  localparam logic [1:0] A_ENABLE  = 2'd1;
  localparam logic [1:0] A_OWNER   = 2'd2;
  localparam logic [1:0] A_TIMEOUT = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    adr = '0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    be = '0;
  logic [31:0]   wdat = '0;
  logic [31:0]   rdat;
  logic          ack;
  logic [NC-1:0] creq = '0;
  logic [NC-1:0] csreq = '0;
  logic [NC-1:0] cdone;
  logic [NC-1:0] cact;
  logic          sreq_o;
  logic          ssreq_o;
  logic          sdone = 1'b0;
  logic          sact = 1'b0;
  logic          intr;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  sdma_intr_hub #(
    .NUM_CLIENTS     (NC),
    .OWNER_W         (3),
    .TIMEOUT_DEFAULT (16'd4096)
  ) dut (
    .WB_CLK          (clk),
    .WB_RST_n        (rst_n),
    .WBs_ADR_i       (adr),
    .WBs_CYC_i       (cyc),
    .WBs_STB_i       (stb),
    .WBs_WE_i        (we),
    .WBs_BYTE_STB_i  (be),
    .WBs_WR_DAT_i    (wdat),
    .WBs_RD_DAT_o    (rdat),
    .WBs_ACK_o       (ack),
    .Client_Req_i    (creq),
    .Client_Sreq_i   (csreq),
    .Client_Done_o   (cdone),
    .Client_Active_o (cact),
    .SDMA_Req_o      (sreq_o),
    .SDMA_Sreq_o     (ssreq_o),
    .SDMA_Done_i     (sdone),
    .SDMA_Active_i   (sact),
    .Intr_o          (intr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_cycle(input logic [1:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] r);
    int n;
    n = 0;
    adr = a; we = w; wdat = d; be = b; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    while (!ack && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("wb_ack", 32'(ack), 32'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; be = '0; wdat = '0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    wb_cycle(a, 1'b1, d, b, r);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] r);
    wb_cycle(a, 1'b0, '0, 4'h0, r);
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (!sreq_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant"}, 32'(sreq_o), 32'd1);
  endtask

  // Full transfer for the next expected owner from the scoreboard
  task automatic do_transfer(input string tag);
    int          exp_owner;
    logic [31:0] r;
    logic [NC-1:0] oh;
    wait_grant(tag);
    exp_owner = (exp_q.size() > 0) ? exp_q.pop_front() : 7;
    oh = NC'(1) << exp_owner;
    sact = 1'b1;
    @(negedge clk);
    check({tag, "_active"}, 32'(cact), 32'(oh));
    wb_read(A_OWNER, r);
    check({tag, "_owner"}, r, 32'h0002_0100 | 32'(exp_owner));
    sdone = 1'b1;
    @(negedge clk);
    sdone = 1'b0; sact = 1'b0;
    check({tag, "_done"}, 32'(cdone), 32'(oh));
    check({tag, "_release"}, 32'(sreq_o), 32'd0);
  endtask

  initial begin
    logic [31:0]   r;
    logic [NC-1:0] dsum;
    int            n;
    int            cnt;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({sreq_o, ssreq_o, intr, ack, cdone, cact}), 32'd0);
    check("rst_rdat", rdat, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read(A_TIMEOUT, r); check("rst_timeout", r, 32'd4096);
    wb_read(A_STATUS, r);  check("rst_status", r, 32'd0);
    wb_read(A_ENABLE, r);  check("rst_enable", r, 32'd0);
    wb_read(A_OWNER, r);   check("rst_owner", r, 32'd0);

    // Single client 1, fixed priority, done interrupt enabled
    wb_write(A_ENABLE, 32'h0000_0002, 4'hF);
    creq = 4'b0010; csreq = 4'b0010;
    @(negedge clk);
    check("t1_req_n1", 32'(sreq_o), 32'd1);
    check("t1_sreq", 32'(ssreq_o), 32'd1);
    check("t1_act_in_req", 32'(cact), 32'd0);
    repeat (2) @(negedge clk);
    sact = 1'b1;
    @(negedge clk);
    check("t1_active", 32'(cact), 32'b0010);
    check("t1_req_pass", 32'(sreq_o), 32'd1);
    sdone = 1'b1;
    @(negedge clk);
    sdone = 1'b0; sact = 1'b0; creq = '0; csreq = '0;
    check("t1_done", 32'(cdone), 32'b0010);
    check("t1_rel_req", 32'(sreq_o), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(cdone), 32'd0);
    check("t1_intr_set", 32'(intr), 32'd1);
    wb_read(A_STATUS, r); check("t1_status", r, 32'h0000_0002);
    wb_write(A_STATUS, 32'h0000_0002, 4'hF);
    @(negedge clk);
    check("t1_intr_clr", 32'(intr), 32'd0);
    wb_read(A_STATUS, r); check("t1_status_clr", r, 32'd0);

    // Fixed priority with all clients requesting, then client 3 alone
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    creq = 4'hF;
    do_transfer("fix_a");
    do_transfer("fix_b");
    do_transfer("fix_c");
    creq = 4'b1000;
    exp_q.push_back(3);
    do_transfer("fix_3");
    creq = '0;

    // Round robin starting from pointer 0
    wb_write(A_ENABLE, 32'h8000_0002, 4'hF);
    wb_read(A_ENABLE, r); check("rr_enable_rb", r, 32'h8000_0002);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    creq = 4'hF;
    do_transfer("rr_0");
    do_transfer("rr_1");
    do_transfer("rr_2");
    do_transfer("rr_3");
    do_transfer("rr_4");
    creq = '0;

    // Timeout with byte-enabled limit writes
    wb_write(A_STATUS, 32'hFFFF_FFFF, 4'hF);
    wb_write(A_TIMEOUT, 32'h1234_0008, 4'b0001);
    wb_read(A_TIMEOUT, r); check("tmo_be_lo", r, 32'h0000_1008);
    wb_write(A_TIMEOUT, 32'h0000_0000, 4'b0010);
    wb_read(A_TIMEOUT, r); check("tmo_be_hi", r, 32'h0000_0008);
    creq = 4'b0100;
    wait_grant("tmo");
    cnt = 0; dsum = '0;
    while (sreq_o && cnt < 40) begin
      cnt++;
      dsum |= cdone;
      @(negedge clk);
    end
    creq = '0;
    check("tmo_req_cycles", 32'(cnt), 32'd9);
    check("tmo_no_done", 32'(dsum), 32'd0);
    wb_read(A_STATUS, r); check("tmo_status", r, 32'h0000_0400);

    // Cancel: client 3 withdraws before Active, client 1 takes over
    creq = 4'b1000;
    @(negedge clk);
    check("cancel_req", 32'(sreq_o), 32'd1);
    creq = 4'b0010;
    @(negedge clk);
    check("cancel_rel", 32'(sreq_o), 32'd0);
    wb_read(A_STATUS, r); check("cancel_status", r, 32'h0000_0400);
    exp_q.push_back(1);
    do_transfer("cancel_next");
    creq = '0;
    wb_read(A_STATUS, r); check("cancel_status2", r, 32'h0000_0402);

    // W1C on the same edge that completes client 0
    wb_write(A_STATUS, 32'hFFFF_FFFF, 4'hF);
    creq = 4'b0001;
    exp_q.push_back(0);
    wait_grant("coll");
    n = exp_q.pop_front();
    sact = 1'b1;
    @(negedge clk);
    check("coll_active", 32'(cact), 32'(NC'(1) << n));
    sdone = 1'b1;
    wb_write(A_STATUS, 32'h0000_0001, 4'hF);
    sdone = 1'b0; sact = 1'b0; creq = '0;
    check("coll_done", 32'(cdone), 32'b0001);
    wb_read(A_STATUS, r); check("coll_status", r, 32'h0000_0001);

    // Asynchronous reset in ACTIVE
    creq = 4'b0001;
    wait_grant("arst");
    sact = 1'b1;
    @(negedge clk);
    check("arst_pre", 32'(cact), 32'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", 32'({sreq_o, ssreq_o, intr, ack, cdone, cact}), 32'd0);
    check("arst_rdat", rdat, 32'd0);
    creq = '0; sact = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read(A_TIMEOUT, r); check("arst_timeout", r, 32'd4096);
    wb_read(A_STATUS, r);  check("arst_status", r, 32'd0);
    wb_read(A_ENABLE, r);  check("arst_enable", r, 32'd0);
    wb_read(A_OWNER, r);   check("arst_owner", r, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
